lms_sequencer: RTL and testbench

Parametrised control sequencer for the two-microphone LMS noise canceller datapath. Per input sample it runs weight update, delay-line shift, new-sample load and filter accumulation over a runtime-selectable tap length for `NUM_CH` reference channels. It then strobes the output write. It sits between the sample-rate strobe generator and the weight/delay-line memories and MAC datapath. It owns the tap and channel counters internally, so the datapath no longer supplies comparator flags.

---
 rtl/lms_sequencer.sv | 239 +++++++++++++++++++++++
 tb/tb_lms_sequencer.sv | 339 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lms_sequencer.sv
// lms_sequencer
// Control sequencer for the two-microphone LMS noise canceller. For every
// accepted input sample it walks each reference channel through weight update,
// delay-line shift and new-sample load, then fetches the main-mic sample,
// accumulates the filter output over all channels and taps, and finally
// strobes the output write. Tap and channel counters are owned here.
//
// Ports
//   clk, rst_n        clock, asynchronous active-low reset
//   start             leave IDLE, latch clamped tap_len, clear overrun
//   stop              return to IDLE (now from WAIT, after the sample otherwise)
//   tap_len           requested filter length L
//   adapt_en          weight adaptation enable, latched with each sample
//   sample_valid      new-sample strobe
//   tap_idx, ch_idx   current tap / channel address
//   weight_update, mem_shift, write_new_mem, read_sub, read_main,
//   compute_acc, write_output
//                     datapath strobes, exactly one group per cycle
//   busy              not IDLE
//   overrun           sticky, a sample strobe arrived while busy
//
// state   | meaning
// S_IDLE  | stopped, waiting for start
// S_WAIT  | armed, waiting for sample_valid
// S_WUPD  | weight update, tap 0..L-1
// S_SHIFT | delay-line shift, tap L-1..1
// S_LOAD  | load new sub-mic sample into tap 0
// S_FETCH | read main-mic sample
// S_ACC   | accumulate weight x delay, all channels, tap 0..L-1
// S_OUT   | write error/output sample

module lms_sequencer #(
    parameter int MAX_TAPS = 32,
    parameter int CNT_W    = 6,
    parameter int NUM_CH   = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             stop,
    input  logic [CNT_W-1:0] tap_len,
    input  logic             adapt_en,
    input  logic             sample_valid,
    output logic [CNT_W-1:0] tap_idx,
    output logic [1:0]       ch_idx,
    output logic             weight_update,
    output logic             mem_shift,
    output logic             write_new_mem,
    output logic             read_sub,
    output logic             read_main,
    output logic             compute_acc,
    output logic             write_output,
    output logic             busy,
    output logic             overrun
);

    typedef enum logic [2:0] {
        S_IDLE, S_WAIT, S_WUPD, S_SHIFT, S_LOAD, S_FETCH, S_ACC, S_OUT
    } state_t;

    localparam logic [CNT_W-1:0] L_MIN   = CNT_W'(2);
    localparam logic [CNT_W-1:0] L_MAX   = CNT_W'(MAX_TAPS);
    localparam logic [1:0]       LAST_CH = 2'(NUM_CH - 1);

    state_t           r_state;
    logic [CNT_W-1:0] r_idx;
    logic [1:0]       r_ch;
    logic [CNT_W-1:0] r_len;
    logic             r_adapt;
    logic             r_stop_pend;
    logic             r_overrun;

    state_t           w_state_nxt;
    logic [CNT_W-1:0] w_idx_nxt;
    logic [1:0]       w_ch_nxt;
    logic [CNT_W-1:0] w_len_clamped;
    logic [CNT_W-1:0] w_len_m1;
    logic             w_accept;

    always_comb begin
        if (tap_len < L_MIN) begin
            w_len_clamped = L_MIN;
        end else if (tap_len > L_MAX) begin
            w_len_clamped = L_MAX;
        end else begin
            w_len_clamped = tap_len;
        end
    end

    assign w_len_m1 = r_len - CNT_W'(1);
    // A stop in WAIT wins over a simultaneous sample strobe.
    assign w_accept = (r_state == S_WAIT) && sample_valid && !stop && !r_stop_pend;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_idx       <= '0;
            r_ch        <= '0;
            r_len       <= L_MIN;
            r_adapt     <= 1'b0;
            r_stop_pend <= 1'b0;
            r_overrun   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_idx   <= w_idx_nxt;
            r_ch    <= w_ch_nxt;
            if ((r_state == S_IDLE) && start) begin
                r_len     <= w_len_clamped;
                r_overrun <= 1'b0;
            end
            if (w_accept) begin
                r_adapt <= adapt_en;
            end
            if (sample_valid && (r_state != S_IDLE) && (r_state != S_WAIT)) begin
                r_overrun <= 1'b1;
            end
            if (r_state == S_OUT) begin
                r_stop_pend <= 1'b0;
            end else if (stop && (r_state != S_IDLE) && (r_state != S_WAIT)) begin
                r_stop_pend <= 1'b1;
            end
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_idx_nxt     = r_idx;
        w_ch_nxt      = r_ch;
        weight_update = 1'b0;
        mem_shift     = 1'b0;
        write_new_mem = 1'b0;
        read_sub      = 1'b0;
        read_main     = 1'b0;
        compute_acc   = 1'b0;
        write_output  = 1'b0;
        tap_idx       = '0;
        ch_idx        = '0;
        busy          = (r_state != S_IDLE);
        overrun       = r_overrun;

        case (r_state)
            S_IDLE: begin
                w_idx_nxt = '0;
                w_ch_nxt  = '0;
                if (start) begin
                    w_state_nxt = S_WAIT;
                end
            end
            S_WAIT: begin
                w_idx_nxt = '0;
                w_ch_nxt  = '0;
                if (stop || r_stop_pend) begin
                    w_state_nxt = S_IDLE;
                end else if (sample_valid) begin
                    if (adapt_en) begin
                        w_state_nxt = S_WUPD;
                    end else begin
                        w_state_nxt = S_SHIFT;
                        w_idx_nxt   = w_len_m1;
                    end
                end
            end
            S_WUPD: begin
                weight_update = 1'b1;
                tap_idx       = r_idx;
                ch_idx        = r_ch;
                if (r_idx == w_len_m1) begin
                    w_state_nxt = S_SHIFT;
                end else begin
                    w_idx_nxt = r_idx + 1'b1;
                end
            end
            S_SHIFT: begin
                mem_shift = 1'b1;
                tap_idx   = r_idx;
                ch_idx    = r_ch;
                if (r_idx == CNT_W'(1)) begin
                    w_state_nxt = S_LOAD;
                    w_idx_nxt   = '0;
                end else begin
                    w_idx_nxt = r_idx - 1'b1;
                end
            end
            S_LOAD: begin
                write_new_mem = 1'b1;
                read_sub      = 1'b1;
                ch_idx        = r_ch;
                if (r_ch != LAST_CH) begin
                    w_ch_nxt = r_ch + 1'b1;
                    if (r_adapt) begin
                        w_state_nxt = S_WUPD;
                        w_idx_nxt   = '0;
                    end else begin
                        w_state_nxt = S_SHIFT;
                        w_idx_nxt   = w_len_m1;
                    end
                end else begin
                    w_state_nxt = S_FETCH;
                    w_ch_nxt    = '0;
                    w_idx_nxt   = '0;
                end
            end
            S_FETCH: begin
                read_main   = 1'b1;
                w_state_nxt = S_ACC;
                w_idx_nxt   = '0;
            end
            S_ACC: begin
                compute_acc = 1'b1;
                tap_idx     = r_idx;
                ch_idx      = r_ch;
                if (r_idx == w_len_m1) begin
                    w_idx_nxt = '0;
                    if (r_ch == LAST_CH) begin
                        w_state_nxt = S_OUT;
                        w_ch_nxt    = '0;
                    end else begin
                        w_ch_nxt = r_ch + 1'b1;
                    end
                end else begin
                    w_idx_nxt = r_idx + 1'b1;
                end
            end
            S_OUT: begin
                write_output = 1'b1;
                // A stop landing in the OUT cycle itself still ends the session.
                if (r_stop_pend || stop) begin
                    w_state_nxt = S_IDLE;
                end else begin
                    w_state_nxt = S_WAIT;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_lms_sequencer.sv
// Testbench for lms_sequencer: directed scenarios followed by a randomized
// phase. Expected strobe events are generated per accepted sample from the
// sequencing rules and queued; a negedge monitor pops and compares them.

module tb_lms_sequencer;

    localparam int MAX_TAPS = 32;
    localparam int CNT_W    = 6;
    localparam int NUM_CH   = 2;

    localparam logic [6:0] V_WUPD  = 7'b1000000;
    localparam logic [6:0] V_SHIFT = 7'b0100000;
    localparam logic [6:0] V_LOAD  = 7'b0011000;
    localparam logic [6:0] V_FETCH = 7'b0000100;
    localparam logic [6:0] V_ACC   = 7'b0000010;
    localparam logic [6:0] V_OUT   = 7'b0000001;

    logic             clk;
    logic             rst_n;
    logic             start;
    logic             stop;
    logic [CNT_W-1:0] tap_len;
    logic             adapt_en;
    logic             sample_valid;
    logic [CNT_W-1:0] tap_idx;
    logic [1:0]       ch_idx;
    logic             weight_update;
    logic             mem_shift;
    logic             write_new_mem;
    logic             read_sub;
    logic             read_main;
    logic             compute_acc;
    logic             write_output;
    logic             busy;
    logic             overrun;

    lms_sequencer #(.MAX_TAPS(MAX_TAPS), .CNT_W(CNT_W), .NUM_CH(NUM_CH)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .start         (start),
        .stop          (stop),
        .tap_len       (tap_len),
        .adapt_en      (adapt_en),
        .sample_valid  (sample_valid),
        .tap_idx       (tap_idx),
        .ch_idx        (ch_idx),
        .weight_update (weight_update),
        .mem_shift     (mem_shift),
        .write_new_mem (write_new_mem),
        .read_sub      (read_sub),
        .read_main     (read_main),
        .compute_acc   (compute_acc),
        .write_output  (write_output),
        .busy          (busy),
        .overrun       (overrun)
    );

    typedef struct {
        logic [6:0] vec;
        int         tap;
        int         ch;
        int         cyc;
        bit         chk_idx;
    } ev_t;

    ev_t q[$];
    int  cyc = 0;
    int  n_checks = 0;
    int  n_fail = 0;
    int  last_out = -1;

    // Reference model state
    bit  m_run = 0;
    int  m_len = 2;
    bit  m_ovr = 0;
    bit  m_pend = 0;
    int  m_wait_from = 0;
    int  m_busy_until = -1;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%0d required=%0d cycle=%0d", name, act, exp, cyc);
        end
    endtask

    always @(negedge clk) begin : monitor
        logic [6:0] v;
        ev_t e;
        if (rst_n) begin
            v = {weight_update, mem_shift, write_new_mem, read_sub,
                 read_main, compute_acc, write_output};
            if (write_output) last_out = cyc;
            if (v != 7'd0 || (q.size() != 0 && q[0].cyc <= cyc)) begin
                if (q.size() == 0) begin
                    chk("unexpected_strobe", 64'(v), 64'd0);
                end else begin
                    e = q.pop_front();
                    chk("strobe_vec", 64'(v), 64'(e.vec));
                    chk("strobe_cyc", 64'(cyc), 64'(e.cyc));
                    if (e.chk_idx) begin
                        chk("tap_idx", 64'(tap_idx), 64'(e.tap));
                        chk("ch_idx", 64'(ch_idx), 64'(e.ch));
                    end
                end
            end
        end
    end

    function automatic int clamp_len(input int len);
        if (len < 2) return 2;
        if (len > MAX_TAPS) return MAX_TAPS;
        return len;
    endfunction

    function automatic void push_ev(input logic [6:0] vec, input int tap, input int ch,
                                    input int c, input bit ci);
        ev_t e;
        e.vec = vec; e.tap = tap; e.ch = ch; e.cyc = c; e.chk_idx = ci;
        q.push_back(e);
    endfunction

    // Expected event list for one sample accepted in cycle t.
    function automatic void push_sample(input int t, input bit adapt);
        int c;
        c = t + 1;
        for (int ch = 0; ch < NUM_CH; ch++) begin
            if (adapt) begin
                for (int i = 0; i < m_len; i++) begin push_ev(V_WUPD, i, ch, c, 1); c++; end
            end
            for (int i = m_len - 1; i >= 1; i--) begin push_ev(V_SHIFT, i, ch, c, 1); c++; end
            push_ev(V_LOAD, 0, ch, c, 1); c++;
        end
        push_ev(V_FETCH, 0, 0, c, 1); c++;
        for (int ch = 0; ch < NUM_CH; ch++) begin
            for (int i = 0; i < m_len; i++) begin push_ev(V_ACC, i, ch, c, 1); c++; end
        end
        push_ev(V_OUT, 0, 0, c, 0);
        m_busy_until = c;
        m_wait_from  = c + 1;
    endfunction

    function automatic void model_update(input int t);
        if (m_run && m_pend && t > m_busy_until) begin
            m_run  = 0;
            m_pend = 0;
        end
    endfunction

    // 0 idle, 1 waiting, 2 processing a sample
    function automatic int mstate(input int t);
        model_update(t);
        if (!m_run) return 0;
        if (t < m_wait_from) return 2;
        return 1;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_until(input int t);
        while (cyc < t) tick();
    endtask

    task automatic do_start(input int len);
        if (mstate(cyc) == 0) begin
            m_run = 1; m_len = clamp_len(len); m_ovr = 0; m_pend = 0;
            m_wait_from = cyc + 1; m_busy_until = cyc;
        end
        tap_len = CNT_W'(len);
        start = 1'b1;
        tick();
        start = 1'b0;
        tap_len = CNT_W'($urandom_range(0, 63));
    endtask

    task automatic do_strobe(input bit adapt, input bit with_stop);
        int s;
        s = mstate(cyc);
        if (s == 2) begin
            m_ovr = 1;
            if (with_stop) m_pend = 1;
        end else if (s == 1) begin
            if (with_stop) m_run = 0;
            else push_sample(cyc, adapt);
        end
        sample_valid = 1'b1;
        adapt_en = adapt;
        stop = with_stop;
        tick();
        sample_valid = 1'b0;
        stop = 1'b0;
        adapt_en = 1'($urandom_range(0, 1));
    endtask

    task automatic do_stop();
        int s;
        s = mstate(cyc);
        if (s == 2) m_pend = 1;
        else if (s == 1) m_run = 0;
        stop = 1'b1;
        tick();
        stop = 1'b0;
    endtask

    task automatic drain(input int budget);
        for (int k = 0; k < budget && q.size() != 0; k++) tick();
        chk("drain", 64'(q.size()), 64'd0);
    endtask

    task automatic chk_busy();
        chk("busy", 64'(busy), 64'(mstate(cyc) != 0));
    endtask

    task automatic chk_all_zero(input string name);
        chk(name, 64'({busy, overrun, tap_idx, ch_idx, weight_update, mem_shift,
                       write_new_mem, read_sub, read_main, compute_acc, write_output}), 64'd0);
    endtask

    task automatic do_async_reset();
        #2 rst_n = 1'b0;
        #1 chk_all_zero("async_reset_outputs");
        q.delete();
        m_run = 0; m_len = 2; m_ovr = 0; m_pend = 0; m_wait_from = 0; m_busy_until = -1;
        repeat (2) tick();
        rst_n = 1'b1;
    endtask

    initial begin
        int c0;
        int gap;
        int r;
        rst_n = 1'b0; start = 1'b0; stop = 1'b0; tap_len = '0;
        adapt_en = 1'b0; sample_valid = 1'b0;
        repeat (3) tick();
        chk_all_zero("reset_outputs");
        rst_n = 1'b1;
        tick();

        // Strobe in IDLE is ignored without overrun
        do_strobe(1, 0);
        chk_busy();
        chk("idle_overrun", 64'(overrun), 64'd0);

        // L=16, adapt on then off, back-to-back strobe one cycle after OUT
        do_start(16);
        chk_busy();
        c0 = cyc; do_strobe(1, 0); drain(300);
        chk("lat_adapt16", 64'(last_out - c0), 64'd98);
        chk("overrun_clean", 64'(overrun), 64'(m_ovr));
        c0 = cyc; do_strobe(0, 0); drain(300);
        chk("lat_noadapt16", 64'(last_out - c0), 64'd66);
        c0 = cyc; do_strobe(0, 0);
        chk("overrun_after_out", 64'(overrun), 64'd0);
        drain(300);
        chk("lat_noadapt16_b", 64'(last_out - c0), 64'd66);

        // Overrun at cycle 40 and in the OUT cycle
        c0 = cyc; do_strobe(1, 0);
        idle_until(c0 + 40); do_strobe(1, 0);
        idle_until(c0 + 98); do_strobe(1, 0);
        chk("overrun_set", 64'(overrun), 64'd1);
        chk("lat_with_overrun", 64'(last_out - c0), 64'd98);
        c0 = cyc; do_strobe(0, 0);
        chk("overrun_sticky", 64'(overrun), 64'd1);
        drain(300);
        chk("lat_after_overrun", 64'(last_out - c0), 64'd66);
        do_stop();
        chk_busy();
        do_start(16);
        chk("overrun_cleared", 64'(overrun), 64'd0);

        // Stop mid-sample: sample completes, then IDLE
        c0 = cyc; do_strobe(1, 0);
        idle_until(c0 + 10); do_stop();
        idle_until(c0 + 99);
        chk("lat_with_stop", 64'(last_out - c0), 64'd98);
        chk_busy();
        do_strobe(1, 0);
        chk_busy();

        // Clamp low and high
        do_start(0);
        c0 = cyc; do_strobe(1, 0); drain(300);
        chk("lat_adapt2", 64'(last_out - c0), 64'd14);
        c0 = cyc; do_strobe(0, 0); drain(300);
        chk("lat_noadapt2", 64'(last_out - c0), 64'd10);
        do_stop();
        do_start(40);
        c0 = cyc; do_strobe(1, 0); drain(400);
        chk("lat_adapt32", 64'(last_out - c0), 64'd194);

        // stop together with sample_valid in WAIT
        do_strobe(1, 1);
        chk_busy();
        repeat (5) tick();
        chk("stop_wins_no_events", 64'(q.size()), 64'd0);

        // Asynchronous reset mid-sample
        do_start(16);
        c0 = cyc; do_strobe(1, 0);
        idle_until(c0 + 50);
        do_async_reset();
        do_strobe(1, 0);
        repeat (3) tick();
        chk_busy();
        do_start(16);
        c0 = cyc; do_strobe(1, 0); drain(300);
        chk("lat_after_reset", 64'(last_out - c0), 64'd98);

        // Randomized phase
        for (int it = 0; it < 40; it++) begin
            if (mstate(cyc) == 0) do_start($urandom_range(0, 63));
            r = $urandom_range(0, 11);
            if (r == 0) do_stop();
            else if (r == 1) do_strobe(1'($urandom_range(0, 1)), 1);
            else do_strobe(1'($urandom_range(0, 1)), 0);
            gap = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 200) : $urandom_range(0, 40);
            repeat (gap) tick();
            chk("rand_overrun", 64'(overrun), 64'(m_ovr));
            chk_busy();
        end
        drain(400);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
